// File: rtl/lc3b_types.sv
// Shared types for the physical-memory arbiter.
// Optional round-robin arbitration is enabled with the PMEM_ARB_RR_EN macro.
package lc3b_types;

  localparam int PMEM_ADDR_W = 16;
  localparam int PMEM_LINE_W = 128;

  typedef logic [PMEM_ADDR_W-1:0] lc3b_pmem_addr;
  typedef logic [PMEM_LINE_W-1:0] lc3b_cache_line;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } pmem_arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } pmem_arb_src_t;

endpackage

// File: rtl/pmem_req_mux.sv
// Picks the request fields that the arbiter latches for the client being granted.
module pmem_req_mux #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              sel_d,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              rd,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [LINE_W-1:0] wdata
);

  always_comb begin
    if (sel_d) begin
      // Read and write together is illegal from dcache; the write-back wins.
      wr    = d_wr;
      rd    = d_rd & ~d_wr;
      addr  = d_addr;
      wdata = d_wdata;
    end else begin
      wr    = 1'b0;
      rd    = 1'b1;
      addr  = i_addr;
      wdata = '0;
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between icache and dcache, one line transfer at a time.
// Define PMEM_ARB_RR_EN for round-robin on ties; otherwise dcache has fixed priority.
module pmem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = PMEM_ADDR_W,
  parameter int LINE_W = PMEM_LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic              i_pmem_resp,
  output logic [LINE_W-1:0] i_pmem_rdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  pmem_arb_state_t   state_q, state_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic              d_req, sel_d;
  logic              mux_rd, mux_wr;
  logic [ADDR_W-1:0] mux_addr;
  logic [LINE_W-1:0] mux_wdata;
  logic              xfer_done;

  assign d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_RR_EN
  pmem_arb_src_t last_grant_q, last_grant_d;
  // On a tie, serve whichever client was not granted last time.
  assign sel_d = d_req & (~i_pmem_read | (last_grant_q == SRC_I));
`else
  assign sel_d = d_req;
`endif

  pmem_req_mux #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) u_req_mux (
    .sel_d  (sel_d),
    .i_addr (i_pmem_address),
    .d_rd   (d_pmem_read),
    .d_wr   (d_pmem_write),
    .d_addr (d_pmem_address),
    .d_wdata(d_pmem_wdata),
    .rd     (mux_rd),
    .wr     (mux_wr),
    .addr   (mux_addr),
    .wdata  (mux_wdata)
  );

  always_comb begin
    // NOTE: every signal gets a hold-value default first so no latch is inferred.
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef PMEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (d_req | i_pmem_read) begin
          state_d = sel_d ? GRANT_D : GRANT_I;
          rd_d    = mux_rd;
          wr_d    = mux_wr;
          addr_d  = mux_addr;
          wdata_d = mux_wdata;
`ifdef PMEM_ARB_RR_EN
          last_grant_d = sel_d ? SRC_D : SRC_I;
`endif
        end
      end
      GRANT_I, GRANT_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the data registers are reset too, so pmem_address/pmem_wdata read zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state always uses non-blocking assignment.
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef PMEM_ARB_RR_EN
      last_grant_q <= SRC_I;
`endif
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef PMEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // A completion arriving while reset is held belongs to an abandoned transfer.
  assign xfer_done    = pmem_resp & ~reset;
  assign i_pmem_resp  = (state_q == GRANT_I) & xfer_done;
  assign d_pmem_resp  = (state_q == GRANT_D) & xfer_done;
  assign i_pmem_rdata = (state_q == GRANT_I) ? pmem_rdata : '0;
  assign d_pmem_rdata = (state_q == GRANT_D) ? pmem_rdata : '0;

  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized scoreboard bench for pmem_arbiter against a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_pmem_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;
`ifdef PMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic          i_pmem_resp;
  logic [LW-1:0] i_pmem_rdata;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic          d_pmem_resp;
  logic [LW-1:0] d_pmem_rdata;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp;
  logic [LW-1:0] pmem_rdata;

  always #5 clk = ~clk;

  pmem_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .i_pmem_read   (i_pmem_read),
    .i_pmem_address(i_pmem_address),
    .i_pmem_resp   (i_pmem_resp),
    .i_pmem_rdata  (i_pmem_rdata),
    .d_pmem_read   (d_pmem_read),
    .d_pmem_write  (d_pmem_write),
    .d_pmem_address(d_pmem_address),
    .d_pmem_wdata  (d_pmem_wdata),
    .d_pmem_resp   (d_pmem_resp),
    .d_pmem_rdata  (d_pmem_rdata),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_resp     (pmem_resp),
    .pmem_rdata    (pmem_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: who owns the memory port and what each grant/response must look like.
  typedef enum int {OWN_NONE = 0, OWN_I = 1, OWN_D = 2} owner_t;
  typedef struct {
    owner_t        who;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } grant_t;
  typedef struct {
    owner_t        who;
    logic [LW-1:0] rdata;
  } resp_t;

  grant_t grant_q[$];
  resp_t  resp_q[$];
  owner_t owner     = OWN_NONE;
  owner_t owner_cur = OWN_NONE;
  owner_t last_win  = OWN_I;
  bit     mon_en    = 1'b0;
  int     lat_cnt   = 0;
  int     lat_tgt   = 4;

  function automatic logic [AW-1:0] rand_addr();
    logic [31:0] r;
    r = $urandom();
    return {r[AW-1:4], 4'h0};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Applies the arbitration rules to the inputs the DUT will sample at the coming edge.
  task automatic model_step();
    bit     dreq, pick_d;
    grant_t g;
    resp_t  r;
    if (reset) begin
      owner    = OWN_NONE;
      last_win = OWN_I;
      return;
    end
    if (owner == OWN_NONE) begin
      dreq = d_pmem_read || d_pmem_write;
      if (dreq || i_pmem_read) begin
        if (!dreq)             pick_d = 1'b0;
        else if (!i_pmem_read) pick_d = 1'b1;
        else                   pick_d = RR ? (last_win == OWN_I) : 1'b1;
        if (pick_d) begin
          g.who = OWN_D; g.wr = d_pmem_write; g.rd = !d_pmem_write;
          g.addr = d_pmem_address; g.wdata = d_pmem_wdata;
        end else begin
          g.who = OWN_I; g.wr = 1'b0; g.rd = 1'b1;
          g.addr = i_pmem_address; g.wdata = '0;
        end
        grant_q.push_back(g);
        owner    = g.who;
        last_win = g.who;
      end
    end else if (pmem_resp) begin
      r.who   = owner;
      r.rdata = pmem_rdata;
      resp_q.push_back(r);
      owner = OWN_NONE;
    end
  endtask

  // One negedge: clients and memory react to last cycle, then the model predicts.
  task automatic cycle(input int p_req, input bit allow_reset);
    bit i_done, d_done;
    int op;
    @(negedge clk);
    i_done    = i_pmem_resp;
    d_done    = d_pmem_resp;
    owner_cur = owner;
    reset     = allow_reset && (owner_cur != OWN_NONE) && ($urandom_range(99) == 0);

    if (i_done || !i_pmem_read) begin
      i_pmem_read = (int'($urandom_range(99)) < p_req);
      i_pmem_address = rand_addr();
    end else if ($urandom_range(9) == 0) begin
      i_pmem_address = rand_addr();
    end

    if (d_done || !(d_pmem_read || d_pmem_write) || $urandom_range(9) == 0) begin
      if ((d_done || !(d_pmem_read || d_pmem_write)) && !(int'($urandom_range(99)) < p_req)) begin
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      end else begin
        op = int'($urandom_range(9));
        d_pmem_read  = (op < 5) || (op == 9);
        d_pmem_write = (op >= 5);
      end
      d_pmem_address = rand_addr();
      d_pmem_wdata   = rand_line();
    end

    pmem_resp = 1'b0;
    if (pmem_read || pmem_write) begin
      if (lat_cnt >= lat_tgt) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
        lat_cnt    = 0;
        lat_tgt    = int'($urandom_range(5));
      end else begin
        lat_cnt++;
      end
    end else if ($urandom_range(15) == 0) begin
      pmem_resp  = 1'b1;
      pmem_rdata = rand_line();
    end
    if (reset) lat_cnt = 0;

    model_step();
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  initial begin
    bit     busy, prev_busy, ir, dr;
    grant_t cur;
    resp_t  r;
    prev_busy = 1'b0;
    cur = '{OWN_NONE, 1'b0, 1'b0, '0, '0};
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        busy = pmem_read || pmem_write;
        check("port_busy", LW'(busy), LW'(owner_cur != OWN_NONE));
        if (busy && !prev_busy) begin
          if (grant_q.size() == 0) begin
            check("grant_unexpected", LW'(1), LW'(0));
          end else begin
            cur = grant_q.pop_front();
            check("grant_rd", LW'(pmem_read), LW'(cur.rd));
            check("grant_wr", LW'(pmem_write), LW'(cur.wr));
            check("grant_addr", LW'(pmem_address), LW'(cur.addr));
            if (cur.who == OWN_D) check("grant_wdata", pmem_wdata, cur.wdata);
          end
        end else if (busy) begin
          check("hold_strobe", LW'({pmem_read, pmem_write}), LW'({cur.rd, cur.wr}));
          check("hold_addr", LW'(pmem_address), LW'(cur.addr));
          if (cur.who == OWN_D) check("hold_wdata", pmem_wdata, cur.wdata);
        end
        prev_busy = busy;

        ir = i_pmem_resp;
        dr = d_pmem_resp;
        if (ir && dr) check("resp_both", LW'(1), LW'(0));
        if (ir || dr) begin
          if (resp_q.size() == 0) begin
            check("resp_unexpected", LW'({ir, dr}), LW'(0));
          end else begin
            r = resp_q.pop_front();
            check("resp_client", LW'(ir ? OWN_I : OWN_D), LW'(r.who));
            check("resp_rdata", ir ? i_pmem_rdata : d_pmem_rdata, r.rdata);
          end
        end else begin
          check("resp_missing", LW'(resp_q.size()), LW'(0));
          resp_q.delete();
        end
      end
    end
  end

  initial begin
    int waited;
    reset = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;

    @(negedge clk);
    mon_en = 1'b1;
    // Requests and a stray completion during reset must not leak through.
    d_pmem_read = 1'b1; i_pmem_read = 1'b1; pmem_resp = 1'b1; pmem_rdata = rand_line();
    @(negedge clk);
    #1;
    check("rst_pmem_read", LW'(pmem_read), LW'(0));
    check("rst_pmem_write", LW'(pmem_write), LW'(0));
    check("rst_pmem_address", LW'(pmem_address), LW'(0));
    check("rst_pmem_wdata", pmem_wdata, '0);
    check("rst_i_resp", LW'(i_pmem_resp), LW'(0));
    check("rst_d_resp", LW'(d_pmem_resp), LW'(0));
    reset = 1'b0;
    d_pmem_read = 1'b0; i_pmem_read = 1'b0; pmem_resp = 1'b0;

    for (int n = 0; n < 3000; n++) cycle(90, 1'b1);
    for (int n = 0; n < 2000; n++) cycle(15, 1'b1);
    for (int n = 0; n < 2000; n++) cycle(60, 1'b0);

    waited = 0;
    while ((i_pmem_read || d_pmem_read || d_pmem_write || owner != OWN_NONE) && waited < 300) begin
      cycle(0, 1'b0);
      waited++;
    end
    check("drain_timeout", LW'(waited >= 300), LW'(0));
    repeat (3) cycle(0, 1'b0);
    check("grant_q_empty", LW'(grant_q.size()), LW'(0));
    check("resp_q_empty", LW'(resp_q.size()), LW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
